// File: rtl/reset_seq_pkg.sv
// Shared definitions for the staged reset sequencer: FSM state codes,
// reset-cause codes and a helper for sizing the stage counter.
package reset_seq_pkg;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_COUNT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_SOFT = 2'd2;
  localparam logic [1:0] CAUSE_WDT  = 2'd3;

  // One counter serves both COUNT and RELEASE, so it is sized for the longer stage.
  function automatic int stage_cnt_width(input int hold_cycles, input int stage_gap);
    int longest;
    longest = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
    return (longest < 2) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/lock_qualifier.sv
// Brings the asynchronous PLL lock into clk_core and qualifies it: lock_q is
// high only after LOCK_WINDOW consecutive synchronized high samples.
module lock_qualifier
  import reset_seq_pkg::*;
#(
  parameter int LOCK_WINDOW = 4
) (
  input  logic clk_core,
  input  logic resetn,
  input  logic pll_locked,
  output logic lock_q
);

  logic                   sync1;
  logic                   sync2;
  logic [LOCK_WINDOW-1:0] window;

  // NOTE: clocked state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; a blocking chain would
  // collapse the synchronizer into a single stage.
  always_ff @(posedge clk_core or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      sync2 <= sync1;
    end
  end

  // A single low sample shifts in and drops qualification on the next edge.
  generate
    if (LOCK_WINDOW == 1) begin : g_single
      always_ff @(posedge clk_core or negedge resetn) begin
        if (!resetn) window <= '0;
        else         window <= sync2;
      end
    end else begin : g_shift
      always_ff @(posedge clk_core or negedge resetn) begin
        if (!resetn) window <= '0;
        else         window <= {window[LOCK_WINDOW-2:0], sync2};
      end
    end
  endgenerate

  assign lock_q = &window;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: qualified PLL lock -> peripheral reset release ->
// core reset release, with lock-loss, watchdog and soft-reset re-entry.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int LOCK_WINDOW = 4,
  parameter int HOLD_CYCLES = 128,
  parameter int STAGE_GAP   = 16,
  parameter int WDT_BITS    = 16
) (
  input  logic       clk_core,
  input  logic       resetn,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  input  logic       wdt_enable,
  input  logic       wdt_kick,
  output logic       rst_periph_n,
  output logic       rst_core_n,
  output logic       ready,
  output logic [1:0] cause
);

  localparam int CNT_W = stage_cnt_width(HOLD_CYCLES, STAGE_GAP);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  logic                lock_q;
  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [WDT_BITS-1:0] wdt;
  logic                event_hit;
  logic [1:0]          event_cause;

  lock_qualifier #(
    .LOCK_WINDOW (LOCK_WINDOW)
  ) u_lock_qualifier (
    .clk_core   (clk_core),
    .resetn     (resetn),
    .pll_locked (pll_locked),
    .lock_q     (lock_q)
  );

  // Re-entry events, highest priority first.
  // NOTE: both outputs get a default before any branch so this block can
  // never infer a latch, whatever paths are added later.
  always_comb begin
    event_hit   = 1'b0;
    event_cause = CAUSE_POR;
    if (state != ST_HOLD && !lock_q) begin
      event_hit   = 1'b1;
      event_cause = CAUSE_LOCK;
    end else if (state == ST_RUN && (&wdt)) begin
      event_hit   = 1'b1;
      event_cause = CAUSE_WDT;
    end else if (state == ST_RUN && soft_reset_req) begin
      event_hit   = 1'b1;
      event_cause = CAUSE_SOFT;
    end
  end

  always_ff @(posedge clk_core or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_HOLD;
      cnt          <= '0;
      wdt          <= '0;
      rst_periph_n <= 1'b0;
      rst_core_n   <= 1'b0;
      ready        <= 1'b0;
      cause        <= CAUSE_POR;
    end else if (event_hit) begin
      state        <= ST_HOLD;
      cnt          <= '0;
      wdt          <= '0;
      rst_periph_n <= 1'b0;
      rst_core_n   <= 1'b0;
      ready        <= 1'b0;
      cause        <= event_cause;
    end else begin
      case (state)
        ST_HOLD: begin
          if (lock_q) begin
            state <= ST_COUNT;
            cnt   <= '0;
          end
        end
        ST_COUNT: begin
          if (cnt == HOLD_LAST) begin
            rst_periph_n <= 1'b1;
            state        <= ST_RELEASE;
            cnt          <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt == GAP_LAST) begin
            rst_core_n <= 1'b1;
            ready      <= 1'b1;
            state      <= ST_RUN;
            wdt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          // All-ones is caught as an event above, so the increment never wraps.
          if (!wdt_enable || wdt_kick) wdt <= '0;
          else                         wdt <= wdt + WDT_BITS'(1);
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scenario bench for reset_sequencer: directed timing checks plus a cycle
// lockstep against an age-based behavioural model under random stimulus.
module tb_reset_sequencer;

  localparam int LW      = 4;
  localparam int HOLD    = 128;
  localparam int GAP     = 16;
  localparam int WB      = 8;
  localparam int WDT_MAX = (1 << WB) - 1;
  localparam int RUN_AGE = HOLD + GAP;

  logic       clk_core = 1'b0;
  logic       resetn;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       wdt_enable;
  logic       wdt_kick;
  logic       rst_periph_n;
  logic       rst_core_n;
  logic       ready;
  logic [1:0] cause;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Model: m_age is edges since lock qualified (-1 while held in reset).
  logic [LW+1:0] m_hist;
  int            m_age;
  int            m_wdt;
  logic [1:0]    m_cause;

  always #5 clk_core = ~clk_core;

  reset_sequencer #(
    .LOCK_WINDOW (LW),
    .HOLD_CYCLES (HOLD),
    .STAGE_GAP   (GAP),
    .WDT_BITS    (WB)
  ) dut (
    .clk_core       (clk_core),
    .resetn         (resetn),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .wdt_enable     (wdt_enable),
    .wdt_kick       (wdt_kick),
    .rst_periph_n   (rst_periph_n),
    .rst_core_n     (rst_core_n),
    .ready          (ready),
    .cause          (cause)
  );

  function automatic logic [4:0] model_out();
    return {m_age >= HOLD, m_age >= RUN_AGE, m_age >= RUN_AGE, m_cause};
  endfunction

  function automatic logic [4:0] dut_out();
    return {rst_periph_n, rst_core_n, ready, cause};
  endfunction

  task automatic model_reset();
    m_hist  = '0;
    m_age   = -1;
    m_wdt   = 0;
    m_cause = 2'd0;
    edge_n  = 0;
  endtask

  // Lock counts as qualified when the LW samples taken 3..LW+2 edges ago were all high.
  task automatic model_step();
    logic lq;
    logic in_run;
    lq     = &m_hist[LW+1:2];
    in_run = (m_age >= RUN_AGE);
    if (m_age >= 0 && !lq) begin
      m_age = -1; m_wdt = 0; m_cause = 2'd1;
    end else if (in_run && m_wdt == WDT_MAX) begin
      m_age = -1; m_wdt = 0; m_cause = 2'd3;
    end else if (in_run && soft_reset_req) begin
      m_age = -1; m_wdt = 0; m_cause = 2'd2;
    end else begin
      if (in_run) m_wdt = (!wdt_enable || wdt_kick) ? 0 : m_wdt + 1;
      if (m_age < 0) begin
        if (lq) m_age = 0;
      end else if (m_age < RUN_AGE) begin
        m_age++;
      end
    end
    m_hist = {m_hist[LW:0], pll_locked};
  endtask

  task automatic tick();
    @(posedge clk_core);
    model_step();
    edge_n++;
    @(negedge clk_core);
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (dut_out() !== model_out()) begin
        errors++;
        $display("FAIL lockstep edge %0d: dut %b model %b", edge_n, dut_out(), model_out());
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1; pll_locked = 1'b1; soft_reset_req = 1'b0;
    wdt_enable = 1'b0; wdt_kick = 1'b0;
    #2 resetn = 1'b0;
    #10;
    checks++;
    if (dut_out() !== 5'b00000) begin
      errors++; $display("FAIL reset_values: got %b want 00000", dut_out());
    end
    @(negedge clk_core);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_power_on();
    advance(134);
    checks++;
    if (rst_periph_n !== 1'b0) begin
      errors++; $display("FAIL periph_early edge %0d: got %b want 0", edge_n, rst_periph_n);
    end
    advance(1);
    checks++;
    if ({rst_periph_n, rst_core_n} !== 2'b10) begin
      errors++; $display("FAIL periph_release edge %0d: got %b want 10", edge_n, {rst_periph_n, rst_core_n});
    end
    advance(15);
    checks++;
    if (rst_core_n !== 1'b0) begin
      errors++; $display("FAIL core_early edge %0d: got %b want 0", edge_n, rst_core_n);
    end
    advance(1);
    checks++;
    if ({rst_core_n, ready, cause} !== 4'b1100) begin
      errors++; $display("FAIL core_release edge %0d: got %b want 1100", edge_n, {rst_core_n, ready, cause});
    end
  endtask

  task automatic test_lock_loss();
    advance(499 - edge_n);
    pll_locked = 1'b0;
    advance(1);
    pll_locked = 1'b1;
    advance(2);
    checks++;
    if (rst_periph_n !== 1'b1) begin
      errors++; $display("FAIL lock_loss_early edge %0d: got %b want 1", edge_n, rst_periph_n);
    end
    advance(1);
    checks++;
    if ({rst_periph_n, rst_core_n, ready, cause} !== 5'b00001) begin
      errors++; $display("FAIL lock_loss edge %0d: got %b want 00001", edge_n, dut_out());
    end
    advance(634 - edge_n);
    checks++;
    if (rst_periph_n !== 1'b0) begin
      errors++; $display("FAIL relock_early edge %0d: got %b want 0", edge_n, rst_periph_n);
    end
    advance(1);
    checks++;
    if (rst_periph_n !== 1'b1) begin
      errors++; $display("FAIL relock_periph edge %0d: got %b want 1", edge_n, rst_periph_n);
    end
    advance(16);
    checks++;
    if ({ready, cause} !== 3'b101) begin
      errors++; $display("FAIL relock_ready edge %0d: got %b want 101", edge_n, {ready, cause});
    end
  endtask

  task automatic test_soft();
    advance(5);
    soft_reset_req = 1'b1;
    advance(1);
    soft_reset_req = 1'b0;
    checks++;
    if (dut_out() !== 5'b00010) begin
      errors++; $display("FAIL soft_event edge %0d: got %b want 00010", edge_n, dut_out());
    end
    advance(49);
    soft_reset_req = 1'b1;
    advance(1);
    soft_reset_req = 1'b0;
    advance(78);
    checks++;
    if (rst_periph_n !== 1'b0) begin
      errors++; $display("FAIL soft_periph_early edge %0d: got %b want 0", edge_n, rst_periph_n);
    end
    advance(1);
    checks++;
    if (rst_periph_n !== 1'b1) begin
      errors++; $display("FAIL soft_periph edge %0d: got %b want 1", edge_n, rst_periph_n);
    end
    advance(15);
    checks++;
    if (rst_core_n !== 1'b0) begin
      errors++; $display("FAIL soft_core_early edge %0d: got %b want 0", edge_n, rst_core_n);
    end
    advance(1);
    checks++;
    if ({rst_core_n, ready, cause} !== 4'b1110) begin
      errors++; $display("FAIL soft_core edge %0d: got %b want 1110", edge_n, {rst_core_n, ready, cause});
    end
  endtask

  task automatic test_lock_and_soft();
    advance(3);
    pll_locked = 1'b0;
    advance(1);
    pll_locked = 1'b1;
    advance(2);
    soft_reset_req = 1'b1;
    advance(1);
    soft_reset_req = 1'b0;
    checks++;
    if (dut_out() !== 5'b00001) begin
      errors++; $display("FAIL lock_beats_soft edge %0d: got %b want 00001", edge_n, dut_out());
    end
    advance(150);
    checks++;
    if ({ready, cause} !== 3'b101) begin
      errors++; $display("FAIL lock_soft_recover edge %0d: got %b want 101", edge_n, {ready, cause});
    end
  endtask

  task automatic test_watchdog();
    wdt_enable = 1'b1;
    advance(254);
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL wdt_early edge %0d: got %b want 1", edge_n, ready);
    end
    advance(2);
    checks++;
    if ({rst_periph_n, rst_core_n, ready, cause} !== 5'b00011) begin
      errors++; $display("FAIL wdt_event edge %0d: got %b want 00011", edge_n, dut_out());
    end
    advance(145);
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL wdt_recover edge %0d: got %b want 1", edge_n, ready);
    end
    for (int k = 0; k < 50; k++) begin
      advance(199);
      wdt_kick = 1'b1;
      advance(1);
      wdt_kick = 1'b0;
    end
    checks++;
    if ({ready, cause} !== 3'b111) begin
      errors++; $display("FAIL wdt_kicked edge %0d: got %b want 111", edge_n, {ready, cause});
    end
    wdt_enable = 1'b0;
  endtask

  task automatic test_async_reset();
    soft_reset_req = 1'b1;
    advance(1);
    soft_reset_req = 1'b0;
    advance(134);
    checks++;
    if ({rst_periph_n, rst_core_n, cause} !== 4'b1010) begin
      errors++; $display("FAIL mid_release edge %0d: got %b want 1010", edge_n, {rst_periph_n, rst_core_n, cause});
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (dut_out() !== 5'b00000) begin
      errors++; $display("FAIL async_reset: got %b want 00000", dut_out());
    end
    @(negedge clk_core);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      pll_locked     = ($urandom_range(0, 599) != 0);
      soft_reset_req = ($urandom_range(0, 99) == 0);
      wdt_kick       = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 299) == 0) wdt_enable = ~wdt_enable;
      advance(1);
    end
    pll_locked = 1'b1; soft_reset_req = 1'b0; wdt_kick = 1'b0; wdt_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_lock_loss();
    test_soft();
    test_lock_and_soft();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
